// File: rtl/vdma_frame_buffer_scheduler.sv
// Frame buffer ring scheduler for the VDMA write path and the downstream reader.
// Hands the writer one free buffer address per frame and gives the reader the
// newest completed frame, never letting the writer touch the buffer being read
// or the newest completed one. Unread frames that get superseded are counted.
module vdma_frame_buffer_scheduler #(
    parameter int NUM_BUFFERS = 3,
    parameter int IDX_W       = 3
) (
    input  logic        video_source_clk_i,
    input  logic        video_source_clk_rst_i,
    input  logic        enable_i,
    input  logic [31:0] base_addr_i,
    input  logic [31:0] frame_stride_i,
    input  logic        buff_addr_fifo_full_i,
    output logic        buff_addr_fifo_wr_o,
    output logic [31:0] buff_addr_fifo_data_o,
    input  logic        wr_frame_done_i,
    input  logic        rd_frame_req_i,
    output logic        rd_frame_ack_o,
    output logic        rd_frame_addr_valid_o,
    output logic [31:0] rd_frame_addr_o,
    output logic        rd_frame_repeat_o,
    output logic [15:0] frame_drop_cnt_o,
    output logic        busy_o
);

    // Table is sized to the full index range so every index value is in bounds.
    localparam int               TBL_DEPTH = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BUFFERS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_ISSUE,
        S_WAIT_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_enable_d;
    logic             r_done_d;
    logic [31:0]      r_stride;
    logic [31:0]      r_acc;
    logic [IDX_W-1:0] r_init_cnt;
    logic [31:0]      r_addr [TBL_DEPTH];

    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_lat_idx;
    logic             r_lat_valid;
    logic [IDX_W-1:0] r_rd_idx;
    logic             r_rd_valid;

    logic             r_fifo_wr;
    logic [31:0]      r_fifo_data;
    logic             r_ack;
    logic             r_ack_valid;
    logic [31:0]      r_ack_addr;
    logic             r_ack_repeat;
    logic [15:0]      r_drop_cnt;
    logic [15:0]      w_drop_nxt;

    logic             w_en_rise;
    logic             w_done_rise;
    logic             w_enable_start;
    logic             w_init_last;
    logic             w_push;
    logic             w_complete;
    logic             w_lat_valid_eff;
    logic [IDX_W-1:0] w_lat_idx_eff;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_sel_found;

    assign w_en_rise      = enable_i & ~r_enable_d;
    assign w_done_rise    = wr_frame_done_i & ~r_done_d;
    assign w_enable_start = (r_state == S_IDLE) & w_en_rise;
    assign w_init_last    = (r_init_cnt == LAST_IDX);
    assign w_push         = (r_state == S_ISSUE) & enable_i & ~buff_addr_fifo_full_i;
    assign w_complete     = (r_state == S_WAIT_DONE) & w_done_rise;

    // A completion in this cycle is visible to a same-cycle reader request.
    assign w_lat_valid_eff = w_complete | r_lat_valid;
    assign w_lat_idx_eff   = w_complete ? r_wr_idx : r_lat_idx;

    // State register.
    always_ff @(posedge video_source_clk_i) begin
        if (video_source_clk_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_en_rise) w_state_nxt = S_INIT;
            S_INIT:      if (w_init_last) w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (!enable_i) begin
                    w_state_nxt = S_IDLE;
                end else if (!buff_addr_fifo_full_i) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: if (w_done_rise) w_state_nxt = enable_i ? S_ISSUE : S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Next write buffer: first index after wr_idx owned by neither reader nor latest.
    always_comb begin
        int cand;
        w_sel_idx   = r_wr_idx;
        w_sel_found = 1'b0;
        cand        = 0;
        for (int k = 1; k <= NUM_BUFFERS; k++) begin
            cand = int'(r_wr_idx) + k;
            if (cand >= NUM_BUFFERS) begin
                cand = cand - NUM_BUFFERS;
            end
            if (!w_sel_found &&
                !(r_rd_valid && (cand == int'(r_rd_idx))) &&
                !(r_lat_valid && (cand == int'(r_lat_idx)))) begin
                w_sel_idx   = IDX_W'(cand);
                w_sel_found = 1'b1;
            end
        end
    end

    // Edge detectors for enable and write-done.
    always_ff @(posedge video_source_clk_i) begin
        if (video_source_clk_rst_i) begin
            r_enable_d <= 1'b0;
            r_done_d   <= 1'b0;
        end else begin
            r_enable_d <= enable_i;
            r_done_d   <= wr_frame_done_i;
        end
    end

    // Configuration latch and address table fill, one entry per INIT cycle.
    always_ff @(posedge video_source_clk_i) begin
        if (video_source_clk_rst_i) begin
            r_stride   <= '0;
            r_acc      <= '0;
            r_init_cnt <= '0;
            for (int i = 0; i < TBL_DEPTH; i++) begin
                r_addr[i] <= '0;
            end
        end else if (w_enable_start) begin
            r_stride   <= frame_stride_i;
            r_acc      <= base_addr_i;
            r_init_cnt <= '0;
        end else if (r_state == S_INIT) begin
            r_addr[r_init_cnt] <= r_acc;
            r_acc              <= r_acc + r_stride;
            r_init_cnt         <= r_init_cnt + IDX_W'(1);
        end
    end

    // Write-address push toward the write controller FIFO.
    always_ff @(posedge video_source_clk_i) begin
        if (video_source_clk_rst_i) begin
            r_fifo_wr   <= 1'b0;
            r_fifo_data <= '0;
            r_wr_idx    <= LAST_IDX;
        end else begin
            r_fifo_wr <= w_push;
            if (w_push) begin
                r_fifo_data <= r_addr[w_sel_idx];
                r_wr_idx    <= w_sel_idx;
            end else if (w_enable_start) begin
                r_wr_idx <= LAST_IDX;
            end
        end
    end

    // Buffer ownership: latest completed frame and the frame held by the reader.
    always_ff @(posedge video_source_clk_i) begin
        if (video_source_clk_rst_i) begin
            r_lat_idx   <= '0;
            r_lat_valid <= 1'b0;
            r_rd_idx    <= '0;
            r_rd_valid  <= 1'b0;
        end else if (w_enable_start) begin
            r_lat_valid <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_lat_idx   <= w_lat_idx_eff;
            r_lat_valid <= w_lat_valid_eff & ~rd_frame_req_i;
            if (rd_frame_req_i && w_lat_valid_eff) begin
                r_rd_idx   <= w_lat_idx_eff;
                r_rd_valid <= 1'b1;
            end
        end
    end

    // Reader acknowledge, one cycle after each request; fields cleared otherwise.
    always_ff @(posedge video_source_clk_i) begin
        if (video_source_clk_rst_i) begin
            r_ack        <= 1'b0;
            r_ack_valid  <= 1'b0;
            r_ack_addr   <= '0;
            r_ack_repeat <= 1'b0;
        end else begin
            r_ack        <= rd_frame_req_i;
            r_ack_valid  <= 1'b0;
            r_ack_addr   <= '0;
            r_ack_repeat <= 1'b0;
            if (rd_frame_req_i) begin
                if (w_lat_valid_eff) begin
                    r_ack_valid <= 1'b1;
                    r_ack_addr  <= r_addr[w_lat_idx_eff];
                end else if (r_rd_valid) begin
                    r_ack_valid  <= 1'b1;
                    r_ack_addr   <= r_addr[r_rd_idx];
                    r_ack_repeat <= 1'b1;
                end
            end
        end
    end

    // Drop counter next value: cleared on start, saturating increment on overwrite.
    always_comb begin
        w_drop_nxt = r_drop_cnt;
        if (w_enable_start) begin
            w_drop_nxt = '0;
        end else if (w_complete && r_lat_valid && (r_drop_cnt != 16'hFFFF)) begin
            w_drop_nxt = r_drop_cnt + 16'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge video_source_clk_i) begin
        if (video_source_clk_rst_i) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_nxt;
        end
    end

    assign buff_addr_fifo_wr_o   = r_fifo_wr;
    assign buff_addr_fifo_data_o = r_fifo_data;
    assign rd_frame_ack_o        = r_ack;
    assign rd_frame_addr_valid_o = r_ack_valid;
    assign rd_frame_addr_o       = r_ack_addr;
    assign rd_frame_repeat_o     = r_ack_repeat;
    assign frame_drop_cnt_o      = r_drop_cnt;
    assign busy_o                = (r_state != S_IDLE);

endmodule

// File: doc/vdma_frame_buffer_scheduler.md
Name: vdma_frame_buffer_scheduler

Overview:
Owns the ring of DDR frame buffers shared by the VDMA write path and the downstream frame reader, using triple-or-more buffering. Pushes one write-buffer address per frame into the write controller's buffer-address FIFO and tracks write completion. Hands the newest completed frame to the reader on request. The writer never overwrites the buffer being read or the newest completed one; superseded unread frames are counted as drops.

Parameters:
NUM_BUFFERS, 3, number of frame buffers in the ring; legal range 3..8.
IDX_W, 3, buffer index width; must be >= clog2(NUM_BUFFERS).

Ports:
video_source_clk_i  in  1  single clock for the whole block
video_source_clk_rst_i  in  1  synchronous, active-high reset
enable_i  in  1  scheduler enable; a rising edge latches the configuration and restarts the ring
base_addr_i  in  32  DDR address of buffer 0; sampled on the enable rising edge
frame_stride_i  in  32  byte distance between consecutive buffers; sampled on the enable rising edge
buff_addr_fifo_full_i  in  1  write-address FIFO full
buff_addr_fifo_wr_o  out  1  one-cycle FIFO push strobe
buff_addr_fifo_data_o  out  32  write-buffer address being pushed
wr_frame_done_i  in  1  write controller memory-write-done; acted on at its rising edge only
rd_frame_req_i  in  1  reader requests a frame; single-cycle pulse
rd_frame_ack_o  out  1  one-cycle response to every request
rd_frame_addr_valid_o  out  1  qualifies rd_frame_addr_o during the ack cycle
rd_frame_addr_o  out  32  address of the frame the reader now owns
rd_frame_repeat_o  out  1  ack returned the previously read frame (no new frame available)
frame_drop_cnt_o  out  16  saturating count of completed frames overwritten while unread
busy_o  out  1  high whenever state is not IDLE

Behaviour:
- Reset: all outputs 0. State IDLE. lat_valid=0, rd_valid=0, wr_idx=NUM_BUFFERS-1, address table cleared.
- States: IDLE, INIT, ISSUE, WAIT_DONE.
- IDLE -> INIT on an enable_i rising edge. Latch base and stride. Clear lat_valid, rd_valid and frame_drop_cnt_o. Set wr_idx=NUM_BUFFERS-1.
- INIT: fill the address table by accumulation, addr[0]=base and addr[i]=addr[i-1]+stride, one entry per cycle, NUM_BUFFERS cycles. Sums wrap modulo 2^32. INIT -> ISSUE after the last entry.
- ISSUE selection: scan from (wr_idx+1) mod N upward and pick the first index that is neither rd_idx (when rd_valid) nor lat_idx (when lat_valid). N>=3 guarantees a hit. Selection is combinational.
- ISSUE push: when buff_addr_fifo_full_i=0, assert buff_addr_fifo_wr_o for exactly one cycle with data=addr[selected] (registered, next cycle). Update wr_idx and go to WAIT_DONE. While full, hold in ISSUE and keep wr_o=0.
- ISSUE with enable_i low: go to IDLE with no push.
- WAIT_DONE: on the rising edge of wr_frame_done_i:
  - if lat_valid=1, increment frame_drop_cnt_o, saturating at 0xFFFF;
  - then set lat_idx=wr_idx and lat_valid=1.
  - Next state is ISSUE if enable_i=1, else IDLE. A disable during WAIT_DONE therefore takes effect at the frame boundary.
- Reader handling, active in every state including IDLE. Each rd_frame_req_i produces rd_frame_ack_o exactly one cycle later:
  - lat_valid=1: rd_idx=lat_idx, rd_valid=1, lat_valid=0, addr_valid=1, repeat=0.
  - lat_valid=0 and rd_valid=1: return addr[rd_idx], addr_valid=1, repeat=1.
  - neither valid: addr_valid=0, addr=0, repeat=0.
  - rd_frame_addr_o/valid/repeat are meaningful only during the ack cycle; they return to 0 afterwards.
- Simultaneous write-done edge and rd_frame_req_i in the same cycle: the completion is applied first, so the reader receives the just-completed buffer. The drop rule still applies to any previous unread latest.
- A request during INIT after a re-enable returns addr_valid=0, because the valid flags were cleared.
- A reset asserted mid-operation returns everything to reset values on the next clock. Pending acks and pushes are discarded.

Test Plan:
1. Reset, then enable with base=0x8000_0000, stride=0x0080_0000, FIFO never full -> INIT lasts 3 cycles; a single push of 0x8000_0000; busy_o=1.
2. Pulse done, rd_req, done, done in that order -> pushes 0x8000_0000, 0x8080_0000, 0x8100_0000, 0x8080_0000. Reader ack is 0x8000_0000 with repeat=0. frame_drop_cnt_o=1.
3. rd_req twice with no completion in between -> first ack returns the new frame with repeat=0; second ack returns the same address with repeat=1.
4. Hold FIFO full for 10 cycles in ISSUE -> no wr_o; one push on the first not-full cycle. Also: done edge and rd_req in the same cycle -> ack carries the just-completed address.
5. Deassert enable during WAIT_DONE -> no further push after the done edge; state IDLE; rd_req still served. Re-enable with base=0x4000_0000 -> drop count cleared; first push 0x4000_0000; rd_req before any completion acks with addr_valid=0.
6. Force 65 540 drops -> frame_drop_cnt_o saturates at 0xFFFF. Assert reset in WAIT_DONE -> all outputs 0 on the next cycle.
